// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit layout, type codes and parser state encoding shared by the NoC adapters
package noc_flit_pkg;
   localparam int FLIT_W  = 37;
   localparam int TYPE_HI = 36;
   localparam int TYPE_LO = 35;
   localparam int VC_HI   = 34;
   localparam int VC_LO   = 32;
   localparam int DEST_HI = 31;
   localparam int DEST_LO = 28;
   localparam int SRC_HI  = 27;
   localparam int SRC_LO  = 24;
   localparam int RW_BIT  = 0;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   typedef enum logic [1:0] {
      FT_BODY = 2'b00,
      FT_TAIL = 2'b01,
      FT_HEAD = 2'b10,
      FT_INV  = 2'b11
   } flit_type_e;
   typedef enum logic [3:0] {
      S_IDLE,
      S_GET_BODY,
      S_GET_TAIL,
      S_DROP,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_RESP,
      S_RESP
   } sna_state_e;
endpackage

// File: rtl/sna_axil_master.sv
// sna_axil_master: AXI4-Lite channel sequencing for one reassembled request
module sna_axil_master
   import noc_flit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  sna_state_e  state,
   input  logic        start_wr,
   input  logic        start_rd,
   output logic        awvalid,
   input  logic        awready,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic        wr_sent,
   output logic        ar_sent,
   output logic        b_done,
   output logic        r_done,
   output logic [1:0]  resp_code,
   output logic [31:0] resp_data
);
   assign bready  = state == S_WR_RESP;
   assign rready  = state == S_RD_RESP;
   assign b_done  = bvalid & bready;
   assign r_done  = rvalid & rready;
   assign wr_sent = (state == S_WR_REQ) & (~awvalid | awready) & (~wvalid | wready);
   assign ar_sent = (state == S_RD_REQ) & arvalid & arready;
   // request valids rise after the tail is accepted and each falls only on its own handshake
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         arvalid <= 1'b0;
      end else begin
         awvalid <= start_wr | (awvalid & ~awready);
         wvalid  <= start_wr | (wvalid & ~wready);
         arvalid <= start_rd | (arvalid & ~arready);
      end
   // capture the completion on the B or R handshake edge; writes carry no data
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         resp_code <= 2'b00;
         resp_data <= 32'd0;
      end else if (b_done) begin
         resp_code <= bresp;
         resp_data <= 32'd0;
      end else if (r_done) begin
         resp_code <= rresp;
         resp_data <= rdata;
      end
endmodule

// File: rtl/sna_flit_parser.sv
// sna_flit_parser: slave-side NoC request deframer executing each packet as an AXI4-Lite transaction
module sna_flit_parser
   import noc_flit_pkg::*;
#(
   parameter logic [3:0] LOCAL_ADDR = 4'b0010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic              flit_valid,
   output logic              flit_ready,
   output logic [31:0]       awaddr,
   output logic [2:0]        awprot,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [31:0]       araddr,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [3:0]        resp_src,
   output logic [2:0]        resp_vc,
   output logic              resp_is_read,
   output logic [1:0]        resp_code,
   output logic [31:0]       resp_data,
   output logic              proto_err
);
   sna_state_e state, state_n, hdr_state;
   flit_type_e ftype;
   logic [31:0] addr_q, data_q;
   logic flit_hs, dest_ok, is_rd, err_n, ld_hdr, ld_addr, ld_data, start_wr, start_rd;
   logic wr_sent, ar_sent, b_done, r_done;
   assign ftype      = flit_type_e'(flit_in[TYPE_HI:TYPE_LO]);
   assign flit_ready = state inside {S_IDLE, S_GET_BODY, S_GET_TAIL, S_DROP};
   assign flit_hs    = flit_valid & flit_ready;
   assign dest_ok    = flit_in[DEST_HI:DEST_LO] == LOCAL_ADDR;
   assign is_rd      = flit_in[RW_BIT] == RW_READ;
   assign hdr_state  = !dest_ok ? S_DROP : is_rd ? S_GET_TAIL : S_GET_BODY;
   assign resp_valid = state == S_RESP;
   assign awaddr     = addr_q;
   assign araddr     = addr_q;
   assign wdata      = data_q;
   assign awprot     = 3'b000;
   assign arprot     = 3'b000;
   assign wstrb      = 4'hF;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_n;
   // next state: a header always restarts parsing, even mid-packet or while dropping
   always_comb begin
      state_n  = state;
      err_n    = 1'b0;
      ld_hdr   = 1'b0;
      ld_addr  = 1'b0;
      ld_data  = 1'b0;
      start_wr = 1'b0;
      start_rd = 1'b0;
      if (flit_hs && ftype == FT_HEAD) begin
         ld_hdr  = 1'b1;
         state_n = hdr_state;
         err_n   = !dest_ok || state == S_GET_BODY || state == S_GET_TAIL;
      end else begin
         case (state)
            S_IDLE: err_n = flit_hs;
            S_GET_BODY:
               if (flit_hs) begin
                  ld_addr = ftype == FT_BODY;
                  err_n   = ftype != FT_BODY;
                  state_n = ftype == FT_BODY ? S_GET_TAIL : S_DROP;
               end
            S_GET_TAIL:
               if (flit_hs) begin
                  ld_addr  = ftype == FT_TAIL && resp_is_read;
                  ld_data  = ftype == FT_TAIL && !resp_is_read;
                  start_rd = ld_addr;
                  start_wr = ld_data;
                  err_n    = ftype != FT_TAIL;
                  state_n  = ftype != FT_TAIL ? S_DROP : resp_is_read ? S_RD_REQ : S_WR_REQ;
               end
            S_DROP:    state_n = flit_hs && ftype == FT_TAIL ? S_IDLE : S_DROP;
            S_WR_REQ:  state_n = wr_sent ? S_WR_RESP : S_WR_REQ;
            S_WR_RESP: state_n = b_done ? S_RESP : S_WR_RESP;
            S_RD_REQ:  state_n = ar_sent ? S_RD_RESP : S_RD_REQ;
            S_RD_RESP: state_n = r_done ? S_RESP : S_RD_RESP;
            S_RESP:    state_n = resp_ready ? S_IDLE : S_RESP;
            default:   state_n = S_IDLE;
         endcase
      end
   end
   // packet fields and the registered error pulse
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         proto_err    <= 1'b0;
         resp_src     <= 4'd0;
         resp_vc      <= 3'd0;
         resp_is_read <= 1'b0;
         addr_q       <= 32'd0;
         data_q       <= 32'd0;
      end else begin
         proto_err <= err_n;
         if (ld_hdr) begin
            resp_src     <= flit_in[SRC_HI:SRC_LO];
            resp_vc      <= flit_in[VC_HI:VC_LO];
            resp_is_read <= is_rd;
         end
         if (ld_addr) addr_q <= flit_in[31:0];
         if (ld_data) data_q <= flit_in[31:0];
      end
   sna_axil_master u_axil (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .start_wr  (start_wr),
      .start_rd  (start_rd),
      .awvalid   (awvalid),
      .awready   (awready),
      .wvalid    (wvalid),
      .wready    (wready),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .wr_sent   (wr_sent),
      .ar_sent   (ar_sent),
      .b_done    (b_done),
      .r_done    (r_done),
      .resp_code (resp_code),
      .resp_data (resp_data)
   );
endmodule

// File: tb/tb_sna_flit_parser.sv
// tb_sna_flit_parser: directed packets against a transaction-level scoreboard and an AXI slave model
module tb_sna_flit_parser;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [36:0] flit_in;
   logic flit_valid, flit_ready;
   logic [31:0] awaddr, wdata, araddr, rdata, resp_data;
   logic [2:0] awprot, arprot, resp_vc;
   logic [3:0] wstrb, resp_src;
   logic [1:0] bresp, rresp, resp_code;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic resp_valid, resp_ready, resp_is_read, proto_err;
   always #5 clk = ~clk;
   sna_flit_parser dut (
      .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(flit_ready),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src), .resp_vc(resp_vc),
      .resp_is_read(resp_is_read), .resp_code(resp_code), .resp_data(resp_data), .proto_err(proto_err)
   );
   typedef struct packed {
      logic [3:0]  src;
      logic [2:0]  vc;
      logic        rd;
      logic [1:0]  code;
      logic [31:0] data;
   } resp_t;
   localparam logic [3:0] LOCAL = 4'd2;
   logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
   resp_t exp_resp[$];
   int n_chk = 0, n_fail = 0, err_cnt = 0, axi_cyc = 0, aw_len = 0, w_len = 0;
   int aw_delay = 0, resp_delay = 0;
   logic r_hold = 1'b0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [36:0] hdr(input logic [3:0] dest, input logic [3:0] src,
                                       input logic [2:0] vc, input logic rd);
      return {2'b10, vc, dest, src, 23'd0, rd};
   endfunction

   function automatic logic [36:0] pl(input logic [1:0] t, input logic [2:0] vc, input logic [31:0] p);
      return {t, vc, p};
   endfunction

   task automatic send_flit(input logic [36:0] f, output int stall);
      stall = 0;
      flit_in = f;
      flit_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (flit_ready) break;
         stall++;
         if (stall > 200) begin
            check("flit_accept", flit_ready, 1);
            break;
         end
      end
      @(posedge clk); #1;
      flit_valid = 1'b0;
   endtask

   task automatic wr_pkt(input logic [3:0] src, input logic [2:0] vc, input logic [31:0] a, input logic [31:0] d);
      int s;
      exp_aw.push_back(a);
      exp_w.push_back(d);
      exp_resp.push_back(resp_t'({src, vc, 1'b0, bresp_cfg, 32'd0}));
      send_flit(hdr(LOCAL, src, vc, 1'b0), s);
      send_flit(pl(2'b00, 3'd5, a), s);
      send_flit(pl(2'b01, 3'd6, d), s);
   endtask

   task automatic rd_pkt(input logic [3:0] src, input logic [2:0] vc, input logic [31:0] a);
      int s;
      exp_ar.push_back(a);
      exp_resp.push_back(resp_t'({src, vc, 1'b1, rresp_cfg, rdata_cfg}));
      send_flit(hdr(LOCAL, src, vc, 1'b1), s);
      send_flit(pl(2'b01, 3'd7, a), s);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(flit_ready && exp_resp.size() == 0) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("idle_reached", {flit_ready, exp_resp.size() == 0}, 2'b11);
   endtask

   task automatic resp_latency(input string name);
      int lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check(name, lat, 3);
   endtask

   // AXI slave and response consumer: readies and responses change just after the clock edge
   initial begin
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic got_aw, got_w, got_ar;
      int aw_cnt, rs_cnt;
      got_aw = 0; got_w = 0; got_ar = 0; aw_cnt = 0; rs_cnt = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rresp = 0; rdata = 0; resp_ready = 0;
      forever begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready;
         ar_hs = arvalid && arready;
         r_hs  = rvalid && rready;
         @(posedge clk); #1;
         if (!rst_n) begin
            got_aw = 0; got_w = 0; got_ar = 0; aw_cnt = 0; rs_cnt = 0;
            bvalid = 0; rvalid = 0; awready = 0; wready = 0; arready = 0; resp_ready = 0;
         end else begin
            got_aw |= aw_hs;
            got_w  |= w_hs;
            got_ar |= ar_hs;
            if (b_hs) bvalid = 0;
            else if (got_aw && got_w) begin
               bvalid = 1; bresp = bresp_cfg; got_aw = 0; got_w = 0;
            end
            if (r_hs) rvalid = 0;
            else if (got_ar && !r_hold) begin
               rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; got_ar = 0;
            end
            awready = awvalid && aw_cnt >= aw_delay;
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            wready  = wvalid;
            arready = arvalid;
            resp_ready = resp_valid && rs_cnt >= resp_delay;
            rs_cnt = resp_valid ? rs_cnt + 1 : 0;
         end
      end
   end

   // compare process: every handshake against the scoreboard, plus protocol invariants
   initial begin
      logic pav, par, pwv, pwr, prv, prr, prsv, prsr;
      resp_t pr, cur;
      int aw_run, w_run;
      pav = 0; par = 0; pwv = 0; pwr = 0; prv = 0; prr = 0; prsv = 0; prsr = 0; pr = '0;
      aw_run = 0; w_run = 0;
      forever begin
         @(negedge clk);
         cur = resp_t'({resp_src, resp_vc, resp_is_read, resp_code, resp_data});
         if (!rst_n) begin
            pav = 0; pwv = 0; prv = 0; prsv = 0; aw_run = 0; w_run = 0;
         end else begin
            if (proto_err) err_cnt++;
            if (awvalid || wvalid || arvalid) axi_cyc++;
            if (awvalid || wvalid || arvalid || bready || rready || resp_valid)
               check("flit_ready_blocked", flit_ready, 0);
            if (bready) check("bready_after_aw_w", {awvalid, wvalid}, 0);
            if (pav && !par) check("awvalid_hold", awvalid, 1);
            if (pwv && !pwr) check("wvalid_hold", wvalid, 1);
            if (prv && !prr) check("arvalid_hold", arvalid, 1);
            if (prsv && !prsr) check("resp_stable", {resp_valid, cur}, {1'b1, pr});
            if (awvalid) aw_run++;
            if (wvalid) w_run++;
            if (awvalid && awready) begin
               aw_len = aw_run; aw_run = 0;
               check("aw_expected", exp_aw.size() > 0, 1);
               if (exp_aw.size() > 0) check("awaddr", {awprot, awaddr}, {3'b000, exp_aw.pop_front()});
            end
            if (wvalid && wready) begin
               w_len = w_run; w_run = 0;
               check("w_expected", exp_w.size() > 0, 1);
               if (exp_w.size() > 0) check("wdata", {wstrb, wdata}, {4'hF, exp_w.pop_front()});
            end
            if (arvalid && arready) begin
               check("ar_expected", exp_ar.size() > 0, 1);
               if (exp_ar.size() > 0) check("araddr", {arprot, araddr}, {3'b000, exp_ar.pop_front()});
            end
            if (resp_valid && resp_ready) begin
               check("resp_expected", exp_resp.size() > 0, 1);
               if (exp_resp.size() > 0) check("resp_fields", cur, exp_resp.pop_front());
            end
            pav = awvalid; par = awready; pwv = wvalid; pwr = wready;
            prv = arvalid; prr = arready; prsv = resp_valid; prsr = resp_ready; pr = cur;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, a0, s, st;
      flit_in = '0;
      flit_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", {flit_ready, awvalid, wvalid, arvalid, bready, rready, resp_valid, proto_err}, 8'b1000_0000);
      check("reset_addr", {awaddr, wdata, araddr}, 96'd0);
      check("reset_resp", {resp_src, resp_vc, resp_is_read, resp_code, resp_data}, 42'd0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      // basic write, minimum latency, literal response fields
      wr_pkt(4'd1, 3'd3, 32'h4000_0010, 32'hDEAD_BEEF);
      resp_latency("wr_latency");
      check("wr_resp_literal", {resp_src, resp_vc, resp_is_read, resp_code, resp_data}, {4'd1, 3'd3, 1'b0, 2'b00, 32'd0});
      wait_idle();
      // basic read
      rdata_cfg = 32'h1234_5678;
      rd_pkt(4'd4, 3'd2, 32'h4000_0020);
      resp_latency("rd_latency");
      check("rd_resp_literal", {resp_src, resp_vc, resp_is_read, resp_code, resp_data}, {4'd4, 3'd2, 1'b1, 2'b00, 32'h1234_5678});
      wait_idle();
      // error response codes with a slow response consumer
      resp_delay = 3;
      bresp_cfg = 2'b10;
      wr_pkt(4'd9, 3'd7, 32'h0000_0004, 32'h0BAD_F00D);
      wait_idle();
      rresp_cfg = 2'b11;
      rdata_cfg = 32'hCAFE_F00D;
      rd_pkt(4'd15, 3'd0, 32'hFFFF_FFFC);
      wait_idle();
      resp_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
      // foreign destination: whole packet dropped, one error, no AXI traffic
      e0 = err_cnt; a0 = axi_cyc; st = 0;
      send_flit(hdr(4'd5, 4'd1, 3'd1, 1'b0), s); st += s;
      send_flit(pl(2'b00, 3'd1, 32'h4000_0040), s); st += s;
      send_flit(pl(2'b01, 3'd1, 32'h1111_2222), s); st += s;
      repeat (3) @(posedge clk);
      #1;
      check("drop_err_once", err_cnt - e0, 1);
      check("drop_no_axi", axi_cyc - a0, 0);
      check("drop_no_stall", st, 0);
      // back in IDLE: stray body and invalid flit each flagged
      send_flit(pl(2'b00, 3'd0, 32'h5555_5555), s);
      send_flit(pl(2'b11, 3'd0, 32'h6666_6666), s);
      repeat (3) @(posedge clk);
      #1;
      check("idle_stray_err", err_cnt - e0, 3);
      // new header abandons the packet in GET_BODY
      e0 = err_cnt;
      send_flit(hdr(LOCAL, 4'd7, 3'd1, 1'b0), s);
      wr_pkt(4'd1, 3'd4, 32'h4000_0050, 32'hA5A5_5A5A);
      wait_idle();
      check("abandon_err", err_cnt - e0, 1);
      // tail in GET_BODY goes to DROP, next tail ends the drop
      e0 = err_cnt;
      send_flit(hdr(LOCAL, 4'd8, 3'd0, 1'b0), s);
      send_flit(pl(2'b01, 3'd0, 32'h7777_7777), s);
      send_flit(pl(2'b01, 3'd0, 32'h8888_8888), s);
      rdata_cfg = 32'h0F0F_0F0F;
      rd_pkt(4'd6, 3'd5, 32'h4000_0060);
      wait_idle();
      check("get_body_tail_err", err_cnt - e0, 1);
      // body in GET_TAIL goes to DROP; a header in DROP starts a fresh packet
      e0 = err_cnt;
      send_flit(hdr(LOCAL, 4'd9, 3'd0, 1'b1), s);
      send_flit(pl(2'b00, 3'd0, 32'h9999_9999), s);
      rdata_cfg = 32'h2468_ACE0;
      rd_pkt(4'd3, 3'd6, 32'h4000_0070);
      wait_idle();
      check("get_tail_body_err", err_cnt - e0, 1);
      // slow AW channel: W completes at once, AW held until accepted
      aw_delay = 4;
      wr_pkt(4'd2, 3'd1, 32'h4000_0080, 32'h1357_9BDF);
      wait_idle();
      aw_delay = 0;
      check("awvalid_cycles", aw_len, 5);
      check("wvalid_cycles", w_len, 1);
      // reset during RD_RESP
      r_hold = 1;
      rd_pkt(4'd3, 3'd4, 32'h4000_0090);
      st = 0;
      while (!rready && st < 20) begin
         @(posedge clk); #1;
         st++;
      end
      check("in_rd_resp", rready, 1);
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check("async_reset_outputs", {arvalid, rready, resp_valid, awvalid, wvalid, bready, proto_err, flit_ready}, 8'b0000_0001);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      r_hold = 0;
      exp_resp.delete();
      @(posedge clk); #1;
      rdata_cfg = 32'hBEEF_0001;
      rd_pkt(4'd5, 3'd3, 32'h4000_00A0);
      resp_latency("rd_after_reset_latency");
      wait_idle();
      check("queues_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_resp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
